// File: rtl/dmux8_scheduler.sv
// dmux8_scheduler: round-robin 1-to-8 demux delivering one held word per transaction,
// with per-channel acknowledge timeout, sticky error flags and a delivery counter.
module dmux8_scheduler #(
    parameter int DATA_W  = 1,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [7:0]        en_mask,
    input  logic [7:0]        out_ack,
    output logic [7:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        sel,
    output logic [7:0]        err,
    input  logic              err_clr,
    output logic [7:0]        xfer_cnt
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t     state;
    logic [2:0] ptr;
    logic [2:0] pick;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       ack;
    logic       tmo;
    // descending scan so the lowest offset from ptr wins
    always_comb begin
        pick = ptr;
        for (int i = 7; i >= 0; i--)
            if (en_mask[ptr + 3'(i)]) pick = ptr + 3'(i);
    end
    assign in_ready = !rst && state == IDLE && |en_mask;
    assign accept   = in_valid && in_ready;
    assign ack      = state == SEND && out_ack[sel];
    assign tmo      = state == SEND && !out_ack[sel] && wait_cnt == 8'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            out_valid <= '0;
            out_data  <= '0;
            err       <= '0;
            xfer_cnt  <= '0;
            wait_cnt  <= '0;
        end else begin
            err <= (err_clr ? 8'd0 : err) | (tmo ? 8'd1 << sel : 8'd0);
            if (state == IDLE) begin
                if (accept) begin
                    state     <= SEND;
                    out_data  <= in_data;
                    sel       <= pick;
                    out_valid <= 8'd1 << pick;
                    wait_cnt  <= '0;
                end
            end else if (ack || tmo) begin
                state     <= IDLE;
                out_valid <= '0;
                ptr       <= sel + 3'd1;
                xfer_cnt  <= ack ? xfer_cnt + 8'd1 : xfer_cnt;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_dmux8_scheduler.sv
// tb_dmux8_scheduler: scenario tasks plus randomized deliveries checked against a
// transaction-level model of pointer, error flags and delivery count.
module tb_dmux8_scheduler;
    localparam int DW = 8;
    localparam int TO = 15;
    logic          clk = 0;
    logic          rst = 1;
    logic          in_valid = 0;
    logic [DW-1:0] in_data = 0;
    logic          in_ready;
    logic [7:0]    en_mask = 0;
    logic [7:0]    out_ack = 0;
    logic [7:0]    out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    sel;
    logic [7:0]    err;
    logic          err_clr = 0;
    logic [7:0]    xfer_cnt;
    int checks = 0;
    int errors = 0;
    int m_ptr = 0;
    logic [7:0] m_err = 0;
    logic [7:0] m_xfer = 0;

    dmux8_scheduler #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .en_mask(en_mask), .out_ack(out_ack), .out_valid(out_valid), .out_data(out_data),
        .sel(sel), .err(err), .err_clr(err_clr), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    function automatic int pick_model(input logic [7:0] m);
        for (int i = 0; i < 8; i++)
            if (m[(m_ptr + i) % 8]) return (m_ptr + i) % 8;
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1; in_valid = 1; en_mask = 8'hFF; out_ack = 0; err_clr = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL rst_out_valid got %h want 00", out_valid); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", sel); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h want 00", out_data); end
        checks++; if (err !== 8'h00) begin errors++; $display("FAIL rst_err got %h want 00", err); end
        checks++; if (xfer_cnt !== 8'h00) begin errors++; $display("FAIL rst_xfer got %0d want 0", xfer_cnt); end
        @(negedge clk);
        rst = 0; in_valid = 0;
        m_ptr = 0; m_err = 0; m_xfer = 0;
    endtask

    // delay = SEND cycles without ack before the ack; delay >= TO means timeout
    task automatic deliver(input logic [7:0] mask, input int delay, input int clr_at);
        logic [DW-1:0] d;
        logic [7:0]    oh;
        int            ch;
        int            last;
        bit            acked;
        d = DW'($urandom);
        ch = pick_model(mask);
        oh = 8'd1 << ch;
        en_mask = mask; in_valid = 1; in_data = d; out_ack = 0; err_clr = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 0; in_data = DW'($urandom); en_mask = 8'($urandom);
        #1;
        checks++; if (sel !== 3'(ch)) begin errors++; $display("FAIL sel got %0d want %0d", sel, ch); end
        checks++; if (out_data !== d) begin errors++; $display("FAIL out_data got %h want %h", out_data, d); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL send_ready got %b want 0", in_ready); end
        acked = 0;
        last = TO;
        for (int k = 1; k <= TO; k++) begin
            checks++; if (out_valid !== oh) begin errors++; $display("FAIL send_valid cyc %0d got %h want %h", k, out_valid, oh); end
            err_clr = (k == clr_at);
            if (k == delay + 1) begin
                out_ack = 8'($urandom) | oh;
                acked = 1;
            end else begin
                out_ack = 8'($urandom) & ~oh;
            end
            en_mask = 8'($urandom);
            @(negedge clk);
            if (acked) begin
                last = k;
                break;
            end
        end
        if (clr_at >= 1 && clr_at <= last) m_err = 0;
        if (acked) m_xfer = m_xfer + 8'd1;
        else m_err = m_err | oh;
        m_ptr = (ch + 1) % 8;
        out_ack = 0; err_clr = 0;
        #1;
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL done_valid got %h want 00", out_valid); end
        checks++; if (xfer_cnt !== m_xfer) begin errors++; $display("FAIL xfer_cnt got %0d want %0d", xfer_cnt, m_xfer); end
        checks++; if (err !== m_err) begin errors++; $display("FAIL err got %h want %h", err, m_err); end
        checks++; if (sel !== 3'(ch)) begin errors++; $display("FAIL sel_hold got %0d want %0d", sel, ch); end
        checks++; if (out_data !== d) begin errors++; $display("FAIL data_hold got %h want %h", out_data, d); end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 8; i++) deliver(8'hFF, 0, 0);
    endtask

    task automatic test_sparse();
        for (int i = 0; i < 3; i++) deliver(8'h24, 0, 0);
    endtask

    task automatic test_no_enable();
        en_mask = 8'h00; in_valid = 1; in_data = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL noen_ready got %b want 0", in_ready); end
            checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL noen_valid got %h want 00", out_valid); end
            @(negedge clk);
        end
        in_valid = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        deliver(8'hFF, TO, 0);
        deliver(8'hFF, 0, 0);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        m_err = 0;
        #1;
        checks++; if (err !== 8'h00) begin errors++; $display("FAIL idle_clr got %h want 00", err); end
        deliver(8'hFF, TO - 1, 0);
    endtask

    task automatic test_clr_collision();
        do_reset();
        deliver(8'h01, TO, 0);
        deliver(8'h08, TO, TO);
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        deliver(8'hFF, 0, 0);
        deliver(8'h10, 0, 0);
        en_mask = 8'h10; in_valid = 1; in_data = 8'h3C;
        @(negedge clk);
        in_valid = 0;
        #1;
        checks++; if (out_valid !== 8'h10) begin errors++; $display("FAIL mid_valid got %h want 10", out_valid); end
        @(negedge clk);
        rst = 1;
        #1;
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL mid_rst_valid got %h want 00", out_valid); end
        checks++; if (xfer_cnt !== 8'h00) begin errors++; $display("FAIL mid_rst_xfer got %0d want 0", xfer_cnt); end
        checks++; if (err !== 8'h00) begin errors++; $display("FAIL mid_rst_err got %h want 00", err); end
        @(negedge clk);
        rst = 0;
        m_ptr = 0; m_err = 0; m_xfer = 0;
        deliver(8'hFF, 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] m;
        int dl;
        int ca;
        for (int i = 0; i < 280; i++) begin
            m = 8'($urandom);
            if (m == 0) m = 8'h80;
            dl = ($urandom % 5 == 0) ? int'($urandom_range(0, TO + 1)) : 0;
            ca = ($urandom % 8 == 0) ? int'($urandom_range(1, TO)) : 0;
            deliver(m, dl, ca);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_sparse();
        test_no_enable();
        test_timeout();
        test_clr_collision();
        test_reset_mid_send();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmux8_scheduler.md
DMUX8_SCHEDULER -- requirements
Module: dmux8_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_W, default 1: width of the data word steered to the outputs.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, range 1..255: maximum number of cycles a delivery waits for its acknowledge.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  source offers a word.
REQ-006 in_data  input  DATA_W  source word.
REQ-007 in_ready  output  1  scheduler accepts the word this cycle.
REQ-008 en_mask  input  8  per-channel enable; a bit at 0 excludes that channel from selection.
REQ-009 out_ack  input  8  per-channel acknowledge from the consumers.
REQ-010 out_valid  output  8  one-hot; its single set bit marks the channel being delivered to.
REQ-011 out_data  output  DATA_W  held word, broadcast to all channels.
REQ-012 sel  output  3  index of the channel currently or last selected.
REQ-013 err  output  8  sticky per-channel timeout flags.
REQ-014 err_clr  input  1  synchronous clear of all err bits.
REQ-015 xfer_cnt  output  8  count of completed deliveries; wraps 255->0.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-017 In IDLE, in_ready SHALL be 1 exactly when en_mask is not all zero; in SEND, in_ready SHALL be 0.
REQ-018 The block SHALL accept a word on the cycle in which in_valid and in_ready are both 1.
  - On the next edge it SHALL register in_data into out_data.
  - It SHALL select a channel and move to SEND.
REQ-019 Channel selection SHALL be round-robin from pointer ptr, initially 0.
  - The chosen channel SHALL be the first index ptr, ptr+1, ... (mod 8) whose en_mask bit is 1 in the accept cycle.
REQ-020 out_valid SHALL be one-hot at bit sel for the whole of SEND and all-zero in IDLE.
  - Latency SHALL be 1 cycle: out_valid is asserted in the cycle after acceptance.
REQ-021 In SEND, out_ack[sel]=1 SHALL complete the delivery on that edge. Completion SHALL:
  - return the FSM to IDLE;
  - set ptr=(sel+1) mod 8;
  - increment xfer_cnt.
REQ-022 out_ack bits other than out_ack[sel] SHALL be ignored.
REQ-023 Changes to en_mask during SEND SHALL NOT affect the delivery in progress.
REQ-024 A wait counter SHALL clear on entry to SEND and increment each SEND cycle without ack.
REQ-025 If out_ack[sel] is still 0 in the TIMEOUT-th SEND cycle, on that edge the block SHALL:
  - drop the word and return to IDLE;
  - set err[sel] and set ptr=(sel+1) mod 8;
  - leave xfer_cnt unchanged.
REQ-026 An ack in the TIMEOUT-th SEND cycle SHALL count as a completion, not a timeout.
REQ-027 When err_clr and an err set occur in the same cycle, the set SHALL win for that bit and all other bits SHALL clear.
REQ-028 sel and out_data SHALL hold their last values in IDLE until the next acceptance.
REQ-029 Peak throughput SHALL be one word per 2 cycles (accept, then ack in the first SEND cycle).

Reset
REQ-030 While rst=1, and immediately on its assertion, the block SHALL force:
  - state IDLE, ptr 0, sel 0;
  - out_valid 0, out_data 0, in_ready 0;
  - err 0, xfer_cnt 0, wait counter 0.
REQ-031 Reset during SEND SHALL discard the held word without setting err or counting it.
REQ-032 The first acceptance after rst deasserts SHALL be possible on the first clk edge at which rst=0.

Verification
REQ-033 Scenario: en_mask=FF; 8 words, each acked in the first SEND cycle -> sel=0,1,...,7, out_valid=01,02,...,80, xfer_cnt=8, err=00.
REQ-034 Scenario: en_mask=0x24 (channels 2 and 5); 3 words acked immediately -> sel=2,5,2.
REQ-035 Scenario: en_mask=00 with in_valid=1 -> in_ready=0 throughout, out_valid=00.
REQ-036 Scenario: TIMEOUT=15, ack withheld on channel 0 -> out_valid=01 for exactly 15 cycles, then IDLE with err=01, xfer_cnt unchanged; next word goes to channel 1.
REQ-037 Scenario: ack arrives in SEND cycle 15 -> completion, err=00; err_clr pulsed during a timeout on channel 3 with err=01 -> err=08.
REQ-038 Scenario: rst pulsed mid-SEND on channel 4 -> out_valid=00 immediately, xfer_cnt=0, next word goes to channel 0.
